// File: rtl/plat_pkg.sv
// Shared types and constants for the multi-platform controller: gadget codes,
// playfield geometry, level ranges and the level-to-pixel size tables.
package plat_pkg;

  typedef enum logic [2:0] {
    EXPAND  = 3'd0,
    SHRINK  = 3'd1,
    FASTER  = 3'd2,
    SLOWER  = 3'd3,
    GRAB    = 3'd4,
    FIRE    = 3'd5,
    BIGGER  = 3'd6,
    SMALLER = 3'd7
  } gadget_e;

  localparam int WALL     = 16;
  localparam int SCREEN_W = 640;

  localparam logic [9:0] X_RST = 10'd320;

  localparam logic [2:0] PLAT_LVL_MIN = 3'd1;
  localparam logic [2:0] PLAT_LVL_MAX = 3'd5;
  localparam logic [2:0] PLAT_LVL_RST = 3'd3;

  localparam logic [1:0] BALL_LVL_MIN = 2'd1;
  localparam logic [1:0] BALL_LVL_MAX = 2'd3;
  localparam logic [1:0] BALL_LVL_RST = 2'd2;

  localparam logic [2:0] SPEED_MIN = 3'd1;
  localparam logic [2:0] SPEED_MAX = 3'd5;
  localparam logic [2:0] SPEED_RST = 3'd3;

  function automatic logic [7:0] plat_hw(input logic [2:0] lvl);
    case (lvl)
      3'd1:    return 8'd8;
      3'd2:    return 8'd16;
      3'd3:    return 8'd32;
      3'd4:    return 8'd64;
      default: return 8'd128;
    endcase
  endfunction

  function automatic logic [5:0] ball_px(input logic [1:0] lvl);
    case (lvl)
      2'd1:    return 6'd3;
      2'd2:    return 6'd5;
      default: return 6'd7;
    endcase
  endfunction

endpackage

// File: rtl/plat_channel.sv
// One platform channel: X slew/clamp, gadget levels and flags, and the
// req/ack collision snapshot. Optional flag lifetime via PLAT_GADGET_TIMER_EN.
module plat_channel
  import plat_pkg::*;
#(
  parameter int MAX_STEP      = 16,
  parameter int GADGET_FRAMES = 600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_start_i,
  input  logic       cal_frame_i,
  input  logic [9:0] gamepad_x_i,
  input  logic       recv_gadget_i,
  input  logic [2:0] gadget_effect_i,
  input  logic       plat_req_i,
  output logic       plat_ack_o,
  output logic [9:0] snap_x_o,
  output logic [7:0] snap_hw_o,
  output logic       grab_o,
  output logic       fire_o,
  output logic [2:0] speed_o,
  output logic [5:0] ball_size_o
);

  localparam logic signed [10:0] WALL_S  = 11'(WALL);
  localparam logic signed [10:0] RIGHT_S = 11'(SCREEN_W - WALL);
  localparam logic signed [10:0] STEP_S  = 11'(MAX_STEP);

  function automatic logic signed [10:0] clamp_s11(input logic signed [10:0] v,
                                                   input logic signed [10:0] lo,
                                                   input logic signed [10:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  function automatic logic signed [10:0] slew_s11(input logic signed [10:0] cur,
                                                  input logic signed [10:0] tgt,
                                                  input logic signed [10:0] stp);
    logic signed [10:0] diff;
    diff = tgt - cur;
    if (diff > stp)       return cur + stp;
    else if (diff < -stp) return cur - stp;
    else                  return tgt;
  endfunction

  logic [9:0] x_q, x_d;
  logic [2:0] plat_lvl_q, plat_lvl_d;
  logic [1:0] ball_lvl_q, ball_lvl_d;
  logic [2:0] speed_q, speed_d;
  logic       grab_q, grab_d;
  logic       fire_q, fire_d;
  logic       ack_q, ack_d;
  logic [9:0] snap_x_q, snap_x_d;
  logic [7:0] snap_hw_q, snap_hw_d;

  logic [7:0]         hw_cur;
  logic signed [10:0] hw_s, lim_lo, lim_hi, tgt_s, x_slew, x_new;

  // Limits always come from the level held before this cycle's gadget lands.
  assign hw_cur = plat_hw(plat_lvl_q);
  assign hw_s   = $signed({3'b000, hw_cur});
  assign lim_lo = WALL_S + hw_s;
  assign lim_hi = RIGHT_S - hw_s;
  assign tgt_s  = clamp_s11($signed({1'b0, gamepad_x_i}), lim_lo, lim_hi);
  assign x_slew = slew_s11($signed({1'b0, x_q}), tgt_s, STEP_S);
  assign x_new  = clamp_s11(x_slew, lim_lo, lim_hi);

  assign x_d       = cal_frame_i ? x_new[9:0] : x_q;
  assign ack_d     = plat_req_i & ~ack_q;
  assign snap_x_d  = ack_d ? x_q : snap_x_q;
  assign snap_hw_d = ack_d ? hw_cur : snap_hw_q;

`ifdef PLAT_GADGET_TIMER_EN
  localparam int TMR_W = (GADGET_FRAMES > 1) ? $clog2(GADGET_FRAMES + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GADGET_FRAMES);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  logic [TMR_W-1:0] grab_tmr_q, grab_tmr_d;
  logic [TMR_W-1:0] fire_tmr_q, fire_tmr_d;
`endif

  always_comb begin
    plat_lvl_d = plat_lvl_q;
    ball_lvl_d = ball_lvl_q;
    speed_d    = speed_q;
    grab_d     = grab_q;
    fire_d     = fire_q;
`ifdef PLAT_GADGET_TIMER_EN
    grab_tmr_d = grab_tmr_q;
    fire_tmr_d = fire_tmr_q;
    if (cal_frame_i) begin
      if (grab_tmr_q != '0) begin
        grab_tmr_d = grab_tmr_q - TMR_ONE;
        if (grab_tmr_q == TMR_ONE) grab_d = 1'b0;
      end
      if (fire_tmr_q != '0) begin
        fire_tmr_d = fire_tmr_q - TMR_ONE;
        if (fire_tmr_q == TMR_ONE) fire_d = 1'b0;
      end
    end
`endif
    if (game_start_i) begin
      plat_lvl_d = PLAT_LVL_RST;
      ball_lvl_d = BALL_LVL_RST;
      speed_d    = SPEED_RST;
      grab_d     = 1'b0;
      fire_d     = 1'b0;
`ifdef PLAT_GADGET_TIMER_EN
      grab_tmr_d = '0;
      fire_tmr_d = '0;
`endif
    end else if (recv_gadget_i) begin
      case (gadget_effect_i)
        EXPAND:  if (plat_lvl_q != PLAT_LVL_MAX) plat_lvl_d = plat_lvl_q + 3'd1;
        SHRINK:  if (plat_lvl_q != PLAT_LVL_MIN) plat_lvl_d = plat_lvl_q - 3'd1;
        FASTER:  if (speed_q != SPEED_MAX) speed_d = speed_q + 3'd1;
        SLOWER:  if (speed_q != SPEED_MIN) speed_d = speed_q - 3'd1;
        BIGGER:  if (ball_lvl_q != BALL_LVL_MAX) ball_lvl_d = ball_lvl_q + 2'd1;
        SMALLER: if (ball_lvl_q != BALL_LVL_MIN) ball_lvl_d = ball_lvl_q - 2'd1;
        GRAB: begin
          grab_d = 1'b1;
`ifdef PLAT_GADGET_TIMER_EN
          grab_tmr_d = TMR_LOAD;
`endif
        end
        FIRE: begin
          fire_d = 1'b1;
`ifdef PLAT_GADGET_TIMER_EN
          fire_tmr_d = TMR_LOAD;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= X_RST;
      plat_lvl_q <= PLAT_LVL_RST;
      ball_lvl_q <= BALL_LVL_RST;
      speed_q    <= SPEED_RST;
      grab_q     <= 1'b0;
      fire_q     <= 1'b0;
      ack_q      <= 1'b0;
      snap_x_q   <= X_RST;
      snap_hw_q  <= plat_hw(PLAT_LVL_RST);
    end else begin
      x_q        <= x_d;
      plat_lvl_q <= plat_lvl_d;
      ball_lvl_q <= ball_lvl_d;
      speed_q    <= speed_d;
      grab_q     <= grab_d;
      fire_q     <= fire_d;
      ack_q      <= ack_d;
      snap_x_q   <= snap_x_d;
      snap_hw_q  <= snap_hw_d;
    end
  end

`ifdef PLAT_GADGET_TIMER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grab_tmr_q <= '0;
      fire_tmr_q <= '0;
    end else begin
      grab_tmr_q <= grab_tmr_d;
      fire_tmr_q <= fire_tmr_d;
    end
  end
`endif

  assign plat_ack_o  = ack_q;
  assign snap_x_o    = snap_x_q;
  assign snap_hw_o   = snap_hw_q;
  assign grab_o      = grab_q;
  assign fire_o      = fire_q;
  assign speed_o     = speed_q;
  assign ball_size_o = ball_px(ball_lvl_q);

endmodule

// File: rtl/platform_multi_ctrl.sv
// Multi-platform controller: NUM_PLAT independent plat_channel instances.
// Define PLAT_GADGET_TIMER_EN to give GRAB/FIRE a GADGET_FRAMES lifetime.
module platform_multi_ctrl
  import plat_pkg::*;
#(
  parameter int NUM_PLAT      = 2,
  parameter int MAX_STEP      = 16,
  parameter int GADGET_FRAMES = 600,
  parameter int PLAT_Y_BASE   = 460,
  parameter int PLAT_Y_PITCH  = -440
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_game_start,
  input  logic                     i_cal_frame,
  input  logic [NUM_PLAT-1:0][9:0] i_gamepad_x,
  input  logic [NUM_PLAT-1:0]      i_recv_gadget,
  input  logic [NUM_PLAT-1:0][2:0] i_gadget_effect,
  input  logic [NUM_PLAT-1:0]      i_plat_req,
  output logic [NUM_PLAT-1:0]      o_plat_ack,
  output logic [NUM_PLAT-1:0][9:0] o_plat_x,
  output logic [NUM_PLAT-1:0][9:0] o_plat_y,
  output logic [NUM_PLAT-1:0][7:0] o_plat_hw,
  output logic [NUM_PLAT-1:0]      o_grab,
  output logic [NUM_PLAT-1:0]      o_fireball,
  output logic [NUM_PLAT-1:0][2:0] o_ball_speed,
  output logic [NUM_PLAT-1:0][5:0] o_ball_size
);

  for (genvar k = 0; k < NUM_PLAT; k++) begin : g_plat
    // Platform rows are fixed, so Y is a per-channel constant.
    localparam int Y_K = PLAT_Y_BASE + k * PLAT_Y_PITCH;
    assign o_plat_y[k] = 10'(Y_K);

    plat_channel #(
      .MAX_STEP      (MAX_STEP),
      .GADGET_FRAMES (GADGET_FRAMES)
    ) u_chan (
      .clk             (clk),
      .rst_n           (rst_n),
      .game_start_i    (i_game_start),
      .cal_frame_i     (i_cal_frame),
      .gamepad_x_i     (i_gamepad_x[k]),
      .recv_gadget_i   (i_recv_gadget[k]),
      .gadget_effect_i (i_gadget_effect[k]),
      .plat_req_i      (i_plat_req[k]),
      .plat_ack_o      (o_plat_ack[k]),
      .snap_x_o        (o_plat_x[k]),
      .snap_hw_o       (o_plat_hw[k]),
      .grab_o          (o_grab[k]),
      .fire_o          (o_fireball[k]),
      .speed_o         (o_ball_speed[k]),
      .ball_size_o     (o_ball_size[k])
    );
  end

endmodule

// File: tb/tb_platform_multi_ctrl.sv
// Scoreboard bench for platform_multi_ctrl: directed stimulus pushes expected
// snapshots and live values; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_platform_multi_ctrl;
  import plat_pkg::*;

  localparam int NP = 2;
`ifdef PLAT_GADGET_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic              clk, rst_n, game_start, cal_frame;
  logic [NP-1:0][9:0] gx;
  logic [NP-1:0]      recv, req, ack, grab, fire;
  logic [NP-1:0][2:0] eff, spd;
  logic [NP-1:0][9:0] px, py;
  logic [NP-1:0][7:0] phw;
  logic [NP-1:0][5:0] bsz;

  platform_multi_ctrl #(
    .NUM_PLAT(NP), .MAX_STEP(16), .GADGET_FRAMES(4),
    .PLAT_Y_BASE(460), .PLAT_Y_PITCH(-440)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_game_start(game_start), .i_cal_frame(cal_frame),
    .i_gamepad_x(gx), .i_recv_gadget(recv), .i_gadget_effect(eff),
    .i_plat_req(req), .o_plat_ack(ack), .o_plat_x(px), .o_plat_y(py),
    .o_plat_hw(phw), .o_grab(grab), .o_fireball(fire),
    .o_ball_speed(spd), .o_ball_size(bsz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int ch; int spd; int sz; int g; int f; int ack; int sx; int shw; string nm;} live_t;
  typedef struct {int ch; int x; int hw; string nm;} snap_t;

  live_t live_q[$];
  snap_t snap_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  // -1 in any field means "not checked in this record"
  task automatic expect_live(input int ch, input int s, input int z, input int g, input int f,
                             input int a, input int sx, input int shw, input string nm);
    live_t e;
    e.ch = ch; e.spd = s; e.sz = z; e.g = g; e.f = f; e.ack = a; e.sx = sx; e.shw = shw; e.nm = nm;
    live_q.push_back(e);
  endtask

  task automatic expect_snap(input int ch, input int x, input int hw, input string nm);
    snap_t s;
    s.ch = ch; s.x = x; s.hw = hw; s.nm = nm;
    snap_q.push_back(s);
  endtask

  initial begin : monitor
    snap_t s;
    live_t e;
    forever begin
      @(negedge clk);
      for (int c = 0; c < NP; c++) begin
        if (ack[c] === 1'b1) begin
          if (snap_q.size() == 0) chk($sformatf("unexpected_ack_ch%0d", c), 1, 0);
          else begin
            s = snap_q.pop_front();
            chk({s.nm, ".ch"}, c, s.ch);
            chk({s.nm, ".x"}, int'(px[c]), s.x);
            chk({s.nm, ".hw"}, int'(phw[c]), s.hw);
          end
        end
      end
      while (live_q.size() > 0) begin
        e = live_q.pop_front();
        chk({e.nm, ".y"}, int'(py[e.ch]), (e.ch == 0) ? 460 : 20);
        if (e.spd >= 0) chk({e.nm, ".speed"}, int'(spd[e.ch]), e.spd);
        if (e.sz >= 0)  chk({e.nm, ".size"}, int'(bsz[e.ch]), e.sz);
        if (e.g >= 0)   chk({e.nm, ".grab"}, int'(grab[e.ch]), e.g);
        if (e.f >= 0)   chk({e.nm, ".fire"}, int'(fire[e.ch]), e.f);
        if (e.ack >= 0) chk({e.nm, ".ack"}, int'(ack[e.ch]), e.ack);
        if (e.sx >= 0)  chk({e.nm, ".snap_x"}, int'(px[e.ch]), e.sx);
        if (e.shw >= 0) chk({e.nm, ".snap_hw"}, int'(phw[e.ch]), e.shw);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    game_start = 1'b0;
    cal_frame  = 1'b0;
    recv       = '0;
  endtask

  task automatic gad(input int ch, input gadget_e g);
    recv[ch] = 1'b1;
    eff[ch]  = g;
  endtask

  task automatic frame();
    cal_frame = 1'b1;
    step();
  endtask

  task automatic samp1(input int ch, input int x, input int hw, input string nm);
    req[ch] = 1'b1;
    step();
    expect_snap(ch, x, hw, nm);
    req[ch] = 1'b0;
    step();
  endtask

  task automatic samp2(input int x0, input int hw0, input int x1, input int hw1, input string nm);
    req = '1;
    step();
    expect_snap(0, x0, hw0, {nm, "_ch0"});
    expect_snap(1, x1, hw1, {nm, "_ch1"});
    req = '0;
    step();
  endtask

  initial begin : stim
    int exp27[3];
    int exp_ack[6];
    exp27   = '{336, 352, 368};
    exp_ack = '{1, 0, 1, 0, 1, 0};
    rst_n = 1'b0; game_start = 1'b0; cal_frame = 1'b0;
    gx = '0; recv = '0; eff = '0; req = '0;

    // Reset state, during and after reset
    step(); step();
    for (int c = 0; c < NP; c++) expect_live(c, 3, 5, 0, 0, 0, 320, 32, "rst_hold");
    rst_n = 1'b1;
    step();
    for (int c = 0; c < NP; c++) expect_live(c, 3, 5, 0, 0, 0, 320, 32, "rst_out");
    samp2(320, 32, 320, 32, "rst_snap");

    // Slew right at MAX_STEP, channel 1 parked at its request
    gx[0] = 10'd600; gx[1] = 10'd320;
    for (int i = 0; i < 3; i++) begin
      frame();
      samp2(exp27[i], 32, 320, 32, $sformatf("slew_right%0d", i));
    end

    // Slew left into the wall clamp, then EXPAND pushes x out by clamp
    gx[0] = 10'd0;
    for (int i = 0; i < 10; i++) frame();
    samp1(0, 208, 32, "slew_left10");
    for (int i = 0; i < 10; i++) frame();
    samp1(0, 48, 32, "left_wall");
    frame(); frame();
    samp1(0, 48, 32, "left_settled");
    gad(0, EXPAND);
    step();
    expect_live(0, 3, 5, 0, 0, -1, -1, -1, "expand_live");
    samp1(0, 48, 64, "expand_no_frame");
    frame();
    samp2(80, 64, 320, 32, "expand_clamp");

    // Held request: ack every second cycle; snapshot ignores later motion
    gx[1] = 10'd600;
    frame(); frame();
    req[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      expect_live(1, -1, -1, -1, -1, exp_ack[i], -1, -1, $sformatf("held_req%0d", i));
      if (exp_ack[i] == 1) expect_snap(1, 352, 32, $sformatf("held_snap%0d", i));
    end
    req[1] = 1'b0;
    step();
    expect_live(1, -1, -1, -1, -1, 0, 352, 32, "req_drop");
    req[1] = 1'b1;
    frame();
    expect_snap(1, 352, 32, "req_with_frame");
    req[1] = 1'b0;
    frame();
    expect_live(1, -1, -1, -1, -1, 0, 352, 32, "snap_hold0");
    frame();
    expect_live(1, -1, -1, -1, -1, 0, 352, 32, "snap_hold1");
    samp2(80, 64, 400, 32, "after_motion");

    // Gadget saturation on channel 1
    for (int i = 0; i < 4; i++) begin
      gad(1, FASTER);
      step();
      expect_live(1, (i == 0) ? 4 : 5, 5, -1, -1, -1, -1, -1, $sformatf("faster%0d", i));
    end
    for (int i = 0; i < 2; i++) begin
      gad(1, SMALLER);
      step();
      expect_live(1, 5, 3, -1, -1, -1, -1, -1, $sformatf("smaller%0d", i));
    end
    for (int i = 0; i < 3; i++) begin gad(1, SHRINK); step(); end
    samp1(1, 400, 8, "shrink_sat");
    gad(1, BIGGER); step();
    expect_live(1, 5, 5, -1, -1, -1, -1, -1, "bigger0");
    gad(1, BIGGER); step();
    expect_live(1, 5, 7, -1, -1, -1, -1, -1, "bigger1");
    gad(1, BIGGER); step();
    expect_live(1, 5, 7, -1, -1, -1, -1, -1, "bigger2");
    gad(1, SLOWER); step();
    expect_live(1, 4, 7, -1, -1, -1, -1, -1, "slower");
    expect_live(0, 3, 5, 0, 0, -1, -1, -1, "ch0_isolated");
    samp1(0, 80, 64, "ch0_isolated_snap");

    // GRAB/FIRE flags: cleared on the 4th frame only when timers are built in
    gad(0, GRAB); gad(1, FIRE);
    step();
    expect_live(0, 3, 5, 1, 0, -1, -1, -1, "grab_set");
    expect_live(1, 4, 7, 0, 1, -1, -1, -1, "fire_set");
    for (int i = 1; i <= 4; i++) begin
      frame();
      expect_live(0, -1, -1, (TMR && i == 4) ? 0 : 1, 0, -1, -1, -1, $sformatf("grab_frame%0d", i));
      expect_live(1, -1, -1, 0, (TMR && i == 4) ? 0 : 1, -1, -1, -1, $sformatf("fire_frame%0d", i));
    end
    samp1(1, 464, 8, "narrow_slew");

    // game_start wins over a same-cycle GRAB; x is kept
    gad(0, GRAB);
    game_start = 1'b1;
    step();
    expect_live(0, 3, 5, 0, 0, -1, -1, -1, "start_ch0");
    expect_live(1, 3, 5, 0, 0, -1, -1, -1, "start_ch1");
    samp2(80, 32, 464, 32, "start_snap");

    // Gadget plus frame: old level clamps this frame, new level next frame
    gad(0, EXPAND);
    frame();
    samp2(64, 64, 480, 32, "expand_with_frame");
    frame();
    samp2(80, 64, 496, 32, "expand_next_frame");

    // Reset while ack is high drops it at once; no ack until a fresh request
    req[1] = 1'b1;
    step();
    expect_live(1, -1, -1, -1, -1, 1, -1, -1, "pre_rst_ack");
    expect_snap(1, 496, 32, "pre_rst_snap");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < NP; c++) expect_live(c, 3, 5, 0, 0, 0, 320, 32, "mid_rst");
    step();
    expect_live(1, -1, -1, -1, -1, 0, 320, 32, "rst_req0");
    step();
    expect_live(1, -1, -1, -1, -1, 0, 320, 32, "rst_req1");
    req[1] = 1'b0;
    rst_n = 1'b1;
    step();
    expect_live(1, 3, 5, 0, 0, 0, 320, 32, "rst_release");
    samp1(1, 320, 32, "post_rst_snap");

    repeat (3) step();
    chk("live_queue_drained", live_q.size(), 0);
    chk("snap_queue_drained", snap_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/platform_multi_ctrl.md
PLATFORM_MULTI_CTRL -- requirements
Module: platform_multi_ctrl

Interface
REQ-001 SHALL have parameter NUM_PLAT, default 2, number of independent platforms (1..4).
REQ-002 SHALL have parameter MAX_STEP, default 16, max platform X movement in pixels per frame.
REQ-003 SHALL have parameter GADGET_FRAMES, default 600, lifetime in frames of timed gadgets.
REQ-004 SHALL have parameters PLAT_Y_BASE (default 460) and PLAT_Y_PITCH (default -440); platform k Y = PLAT_Y_BASE + k*PLAT_Y_PITCH.
REQ-005 SHALL have port clk, input, 1, clock; rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports i_game_start (1) and i_cal_frame (1), inputs, one-cycle pulses.
REQ-007 SHALL have input i_gamepad_x [NUM_PLAT][10], requested platform centre X per channel.
REQ-008 SHALL have inputs i_recv_gadget [NUM_PLAT] and i_gadget_effect [NUM_PLAT][3], per-channel gadget delivery.
REQ-009 SHALL have input i_plat_req [NUM_PLAT] and output o_plat_ack [NUM_PLAT], collision snapshot handshake.
REQ-010 SHALL have outputs o_plat_x [NUM_PLAT][10], o_plat_y [NUM_PLAT][10], o_plat_hw [NUM_PLAT][8], collision snapshot.
REQ-011 SHALL have outputs o_grab, o_fireball [NUM_PLAT][1], o_ball_speed [NUM_PLAT][3], o_ball_size [NUM_PLAT][6], live values.

Function
REQ-012 Per channel SHALL hold: live x, plat size level (1..5 -> half-width 8/16/32/64/128), ball size level (1..3 -> 3/5/7 px), speed step (1..5), grab, fireball, snapshot regs.
REQ-013 On i_cal_frame: target = clamp(i_gamepad_x, WALL+hw, 640-WALL-hw); x moves toward target by min(|target-x|, MAX_STEP); result then re-clamped to current limits (clamp dominates slew).
REQ-014 Arithmetic for slew/clamp SHALL use 11-bit signed intermediates; no wrap-around below 0 or above 639.
REQ-015 Gadgets: EXPAND/SHRINK +/-1 plat level, FASTER/SLOWER +/-1 speed, BIGGER/SMALLER +/-1 ball level, each saturating at range ends; GRAB/FIRE set flag.
REQ-016 Handshake: if i_plat_req=1 and o_plat_ack=0, next cycle o_plat_ack=1 and snapshot <= live x, hw; ack high exactly one cycle; req held high yields ack every second cycle.
REQ-017 Snapshot outputs SHALL change only on an ack cycle; live x updates do not disturb a pending snapshot.
REQ-018 i_game_start SHALL override a same-cycle gadget: plat level 3, ball level 2, speed 3, grab 0, fire 0, timers 0; x unchanged.
REQ-019 Gadget and i_cal_frame in same cycle SHALL both take effect; new level used for clamp from next frame.
REQ-020 Channels SHALL be fully independent; gadget on channel k never alters channel j.

Reset
REQ-021 On rst_n low: x=320, plat level 3 (hw 32), ball level 2 (size 5), speed 3, grab 0, fire 0, ack 0, snapshot x=320 hw=32, timers 0.
REQ-022 Reset mid-handshake SHALL drop ack immediately; no ack issued until a new req sampled after reset release.

Configuration
REQ-023 Macro PLAT_GADGET_TIMER_EN defined: GRAB/FIRE load a per-flag frame counter with GADGET_FRAMES (reload on repeat); decrement on i_cal_frame; flag cleared on frame where counter goes 1->0.
REQ-024 Macro undefined: GRAB/FIRE persist until i_game_start or reset; no counters instantiated.

Structure
REQ-025 Package plat_pkg SHALL hold gadget effect codes (EXPAND=0..SMALLER=7), WALL=16, SCREEN_W=640, size tables, reset levels.
REQ-026 Sub-module plat_channel SHALL implement one channel; top instantiates NUM_PLAT via generate.

Verification
REQ-027 Reset, gamepad 600, 3 frames -> x 336, 352, 368 (MAX_STEP 16).
REQ-028 hw 32, gamepad 0, frames until settled -> x stops at 48; then EXPAND -> next frame x=80.
REQ-029 Req held 6 cycles -> ack pattern 0,1,0,1,0,1; snapshot equals live x at each ack.
REQ-030 FASTER x4 from reset -> speed 4,5,5,5; SMALLER x2 -> size 3,3.
REQ-031 PLAT_GADGET_TIMER_EN, GADGET_FRAMES=4: GRAB then 4 frames -> o_grab cleared on 4th frame; GRAB with game_start same cycle -> o_grab 0.
